// File: rtl/i_cache_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i_cache_fetch_pkg
// Purpose  : Shared constants for the fetch-stage instruction cache:
//            word size, NOP encoding, cache geometry and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package i_cache_fetch_pkg;

  localparam int c_WORD_SIZE      = 16;
  localparam int c_NUM_LINES      = 4;
  localparam int c_WORDS_PER_LINE = 4;

  localparam int c_INDEX_W  = $clog2(c_NUM_LINES);
  localparam int c_OFFSET_W = $clog2(c_WORDS_PER_LINE);
  localparam int c_TAG_W    = c_WORD_SIZE - c_INDEX_W - c_OFFSET_W;

  // NOP is the NOP opcode in the top nibble with all operand bits zero.
  localparam logic [3:0] c_OPCODE_NOP = 4'hF;

  typedef enum logic [0:0] {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } fetch_state_t;

endpackage : i_cache_fetch_pkg
`default_nettype wire

// File: rtl/i_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : i_cache_array
// Purpose  : Valid/tag/data storage of the direct-mapped instruction cache.
// Ports    : clk, rst        - clock, synchronous active-high reset (valid only)
//            i_rd_idx        - combinational read index
//            o_rd_valid/tag/line - read port outputs
//            i_wr_en/idx/tag/line - synchronous whole-line write port
// Revision : 1.0 - initial release
// ============================================================================
module i_cache_array #(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 12,
  parameter int LINE_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_line [NUM_LINES];

  // Only the valid bits are reset; stale tag/data are harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_line[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_line[i_rd_idx];

endmodule : i_cache_array
`default_nettype wire

// File: rtl/i_cache_fetch.sv
`default_nettype none
// ============================================================================
// Module   : i_cache_fetch
// Purpose  : Direct-mapped read-only instruction cache for the fetch stage.
//            Hits return the instruction in the same cycle; a miss stalls
//            fetch, refills one line through a ready handshake, then replays.
// Ports    : clk, reset_n (synchronous, active-high despite the name)
//            fetch_req, pc_IF           - fetch request from the core
//            instruction_IF, tag_match_IF, cache_stall - to IF/ID and hazard
//            i_readM, i_address, i_ready, i_data       - refill interface
//            num_hit, num_miss           - wrapping statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module i_cache_fetch
  import i_cache_fetch_pkg::*;
#(
  parameter int WORD_SIZE      = c_WORD_SIZE,
  parameter int NUM_LINES      = c_NUM_LINES,
  parameter int WORDS_PER_LINE = c_WORDS_PER_LINE
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                fetch_req,
  input  logic [WORD_SIZE-1:0]                pc_IF,
  output logic [WORD_SIZE-1:0]                instruction_IF,
  output logic                                tag_match_IF,
  output logic                                cache_stall,
  output logic                                i_readM,
  output logic [WORD_SIZE-1:0]                i_address,
  input  logic                                i_ready,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] i_data,
  output logic [15:0]                         num_hit,
  output logic [15:0]                         num_miss
);

  localparam int c_IDX_W  = $clog2(NUM_LINES);
  localparam int c_OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int c_TAG_W  = WORD_SIZE - c_IDX_W - c_OFF_W;
  localparam int c_LINE_W = WORD_SIZE * WORDS_PER_LINE;
  localparam logic [WORD_SIZE-1:0] c_NOP = {c_OPCODE_NOP, {(WORD_SIZE-4){1'b0}}};

  fetch_state_t         r_state;
  logic                 r_readM;
  logic [WORD_SIZE-1:0] r_address;
  logic [15:0]          r_num_hit;
  logic [15:0]          r_num_miss;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_OFF_W-1:0]   w_off;
  logic [c_TAG_W-1:0]   w_tag;
  logic                 w_rd_valid;
  logic [c_TAG_W-1:0]   w_rd_tag;
  logic [c_LINE_W-1:0]  w_rd_line;
  logic [WORD_SIZE-1:0] w_words [WORDS_PER_LINE];
  logic                 w_hit;
  logic                 w_wr_en;

  assign w_off = pc_IF[c_OFF_W-1:0];
  assign w_idx = pc_IF[c_OFF_W +: c_IDX_W];
  assign w_tag = pc_IF[WORD_SIZE-1 -: c_TAG_W];

  // The line being refilled is identified by the latched request address,
  // never by pc_IF, so a redirect mid-refill still installs the right line.
  // Reset wins over a coinciding i_ready.
  assign w_wr_en = (r_state == REFILL) & i_ready & ~reset_n;

  i_cache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (c_IDX_W),
    .TAG_W     (c_TAG_W),
    .LINE_W    (c_LINE_W)
  ) u_array (
    .clk        (clk),
    .rst        (reset_n),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_address[c_OFF_W +: c_IDX_W]),
    .i_wr_tag   (r_address[WORD_SIZE-1 -: c_TAG_W]),
    .i_wr_line  (i_data)
  );

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_words
    assign w_words[k] = w_rd_line[k*WORD_SIZE +: WORD_SIZE];
  end

  assign w_hit = fetch_req & (r_state == LOOKUP) & w_rd_valid & (w_rd_tag == w_tag);

  assign tag_match_IF   = w_hit;
  assign instruction_IF = w_hit ? w_words[w_off] : c_NOP;
  assign cache_stall    = fetch_req & ~w_hit;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state    <= LOOKUP;
      r_readM    <= 1'b0;
      r_address  <= '0;
      r_num_hit  <= 16'd0;
      r_num_miss <= 16'd0;
    end else begin
      case (r_state)
        LOOKUP: begin
          if (w_hit) begin
            r_num_hit <= r_num_hit + 16'd1;
          end else if (fetch_req) begin
            r_state    <= REFILL;
            r_readM    <= 1'b1;
            r_address  <= {pc_IF[WORD_SIZE-1:c_OFF_W], {c_OFF_W{1'b0}}};
            r_num_miss <= r_num_miss + 16'd1;
          end
        end
        REFILL: begin
          if (i_ready) begin
            r_state <= LOOKUP;
            r_readM <= 1'b0;
          end
        end
        default: r_state <= LOOKUP;
      endcase
    end
  end

  assign i_readM   = r_readM;
  assign i_address = r_address;
  assign num_hit   = r_num_hit;
  assign num_miss  = r_num_miss;

endmodule : i_cache_fetch
`default_nettype wire
